// File: rtl/mips_pkg.sv
// Shared constants, FSM state and IF/ID record for the MIPS fetch stage.
package mips_pkg;

   localparam logic [31:0] RESET_PC  = 32'h0000_3000;
   localparam logic [31:0] IM_BASE   = 32'h0000_3000;
   localparam int unsigned IM_WORDS  = 4096;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] IM_LIMIT  = IM_BASE + 32'(IM_WORDS * 32'd4);

   typedef enum logic [0:0] {
      BOOT = 1'b0,
      RUN  = 1'b1
   } if_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc8;
      logic        valid;
      logic        exc_adel;
   } if_id_t;

   // Misaligned or outside [IM_BASE, IM_LIMIT) raises an address error.
   function automatic logic fetch_illegal(input logic [31:0] addr);
      return (addr[1:0] != 2'b00) || (addr < IM_BASE) || (addr >= IM_LIMIT);
   endfunction

endpackage

// File: rtl/pc_reg.sv
// Architectural PC register: reset load, hold (stall or BOOT), pc+4 adder.
module pc_reg
   import mips_pkg::*;
#(
   parameter logic [31:0] RST_VAL = RESET_PC
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        hold,
   input  logic [31:0] next_pc,
   output logic [31:0] pc,
   output logic [31:0] pc4
);

   logic [31:0] pc_q;

   // PC flop; reset wins over hold.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc_q <= RST_VAL;
      end else if (!hold) begin
         pc_q <= next_pc;
      end else begin
         pc_q <= pc_q;
      end
   end

   assign pc  = pc_q;
   assign pc4 = pc_q + 32'd4;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, IF/ID register, boot FSM, fetch counter.
// Optional fetch address checking is enabled by defining IF_STAGE_ADDR_CHECK_EN.
module if_stage
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] next_pc,
   input  logic [31:0] instr_in,
   output logic [31:0] im_addr,
   output logic [31:0] pc,
   output logic [31:0] pc4,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc8,
   output logic        id_valid,
   output logic        id_exc_adel,
   output logic [31:0] fetch_count
);

   if_state_t   state, state_next;
   logic        capture, bubble, hold;
   if_id_t      ifid, ifid_next;
   logic [31:0] pc_cur, fcount;

   // BOOT holds the PC for one cycle so the IM output settles.
   assign hold = stall || (state == BOOT);

   pc_reg #(.RST_VAL(RESET_PC)) u_pc_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .hold    (hold),
      .next_pc (next_pc),
      .pc      (pc_cur),
      .pc4     (pc4)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= BOOT;
      end else begin
         state <= state_next;
      end
   end

   // Next state and edge action; stall beats flush.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      bubble     = 1'b0;
      case (state)
         BOOT: state_next = RUN;
         RUN: begin
            if (stall) begin
               capture = 1'b0;
            end else if (flush) begin
               bubble = 1'b1;
            end else begin
               capture = 1'b1;
            end
         end
         default: state_next = BOOT;
      endcase
   end

   // IF/ID next value; a bubble keeps the old pc/pc8.
   always_comb begin
      ifid_next = ifid;
      if (bubble) begin
         ifid_next.instr    = NOP_INSTR;
         ifid_next.valid    = 1'b0;
         ifid_next.exc_adel = 1'b0;
      end else if (capture) begin
         ifid_next.pc    = pc_cur;
         ifid_next.pc8   = pc_cur + 32'd8;
         ifid_next.valid = 1'b1;
`ifdef IF_STAGE_ADDR_CHECK_EN
         if (fetch_illegal(pc_cur)) begin
            ifid_next.instr    = NOP_INSTR;
            ifid_next.exc_adel = 1'b1;
         end else begin
            ifid_next.instr    = instr_in;
            ifid_next.exc_adel = 1'b0;
         end
`else
         ifid_next.instr    = instr_in;
         ifid_next.exc_adel = 1'b0;
`endif
      end else begin
         ifid_next = ifid;
      end
   end

   // IF/ID register and fetch counter.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ifid   <= '{instr: NOP_INSTR, pc: 32'h0, pc8: 32'h0, valid: 1'b0, exc_adel: 1'b0};
         fcount <= 32'd0;
      end else begin
         ifid   <= ifid_next;
         fcount <= capture ? fcount + 32'd1 : fcount;
      end
   end

   assign im_addr     = pc_cur;
   assign pc          = pc_cur;
   assign id_instr    = ifid.instr;
   assign id_pc       = ifid.pc;
   assign id_pc8      = ifid.pc8;
   assign id_valid    = ifid.valid;
   assign id_exc_adel = ifid.exc_adel;
   assign fetch_count = fcount;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage; follows IF_STAGE_ADDR_CHECK_EN when defined.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        reset_n, stall, flush;
   logic [31:0] next_pc, instr_in, im_addr, pc, pc4;
   logic [31:0] id_instr, id_pc, id_pc8, fetch_count;
   logic        id_valid, id_exc_adel;

   int checks   = 0;
   int failures = 0;

   typedef logic [193:0] vec_t;
   vec_t sb[$];
   vec_t exp_v, obs_v;

   // reference model state
   logic [31:0] m_pc, m_instr, m_idpc, m_idpc8, m_fc;
   logic        m_boot, m_valid, m_exc;

   if_stage dut (
      .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
      .next_pc(next_pc), .instr_in(instr_in), .im_addr(im_addr), .pc(pc), .pc4(pc4),
      .id_instr(id_instr), .id_pc(id_pc), .id_pc8(id_pc8), .id_valid(id_valid),
      .id_exc_adel(id_exc_adel), .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] im_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   assign instr_in = im_word(im_addr);

   function automatic logic illegal(input logic [31:0] a);
`ifdef IF_STAGE_ADDR_CHECK_EN
      return (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (a >= 32'h0000_7000);
`else
      return 1'b0;
`endif
   endfunction

   function automatic vec_t observed();
      return {pc, pc4, id_instr, id_pc, id_pc8, id_valid, id_exc_adel, fetch_count};
   endfunction

   // Drive one edge, advance the model, queue its expectation, then settle past the edge.
   task automatic cycle(input logic rn, input logic st, input logic fl, input logic [31:0] np);
      logic bad;
      @(negedge clk);
      reset_n = rn; stall = st; flush = fl; next_pc = np;
      if (!rn) begin
         m_pc = 32'h3000; m_instr = 32'h0; m_idpc = 32'h0; m_idpc8 = 32'h0;
         m_valid = 1'b0; m_exc = 1'b0; m_fc = 32'd0; m_boot = 1'b1;
      end else if (m_boot) begin
         m_boot = 1'b0;
      end else if (st) begin
         m_boot = 1'b0;
      end else if (fl) begin
         m_pc = np; m_instr = 32'h0; m_valid = 1'b0; m_exc = 1'b0;
      end else begin
         bad     = illegal(m_pc);
         m_instr = bad ? 32'h0 : im_word(m_pc);
         m_exc   = bad;
         m_idpc  = m_pc;
         m_idpc8 = m_pc + 32'd8;
         m_valid = 1'b1;
         m_fc    = m_fc + 32'd1;
         m_pc    = np;
      end
      sb.push_back({m_pc, m_pc + 32'd4, m_instr, m_idpc, m_idpc8, m_valid, m_exc, m_fc});
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         cycle(1'b0, 1'b0, 1'b0, 32'h0);
         exp_v = sb.pop_front(); obs_v = observed(); checks++;
         if (obs_v !== exp_v) begin
            failures++; $display("FAIL reset_state got=%h exp=%h", obs_v, exp_v);
         end
      end
      checks++;
      if (pc !== 32'h3000 || id_valid !== 1'b0 || fetch_count !== 32'd0) begin
         failures++; $display("FAIL reset_const pc=%h valid=%b fc=%0d exp pc=3000 valid=0 fc=0", pc, id_valid, fetch_count);
      end
   endtask

   task automatic test_sequential();
      cycle(1'b1, 1'b0, 1'b0, 32'h3004);   // BOOT edge: no capture
      exp_v = sb.pop_front(); obs_v = observed(); checks++;
      if (obs_v !== exp_v || pc !== 32'h3000 || id_valid !== 1'b0) begin
         failures++; $display("FAIL boot_cycle got=%h exp=%h", obs_v, exp_v);
      end
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b0, 1'b0, m_pc + 32'd4);
         exp_v = sb.pop_front(); obs_v = observed(); checks++;
         if (obs_v !== exp_v) begin
            failures++; $display("FAIL seq_fetch%0d got=%h exp=%h", i, obs_v, exp_v);
         end
         checks++;
         if (id_pc !== 32'h3000 + 32'(i * 4) || fetch_count !== 32'(i + 1) || id_pc8 !== id_pc + 32'd8) begin
            failures++; $display("FAIL seq_const%0d id_pc=%h fc=%0d id_pc8=%h", i, id_pc, fetch_count, id_pc8);
         end
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b1, 1'b0, $urandom);
         exp_v = sb.pop_front(); obs_v = observed(); checks++;
         if (obs_v !== exp_v || pc !== 32'h3010 || fetch_count !== 32'd4) begin
            failures++; $display("FAIL stall_hold%0d got=%h exp=%h", i, obs_v, exp_v);
         end
      end
      cycle(1'b1, 1'b0, 1'b0, 32'h3014);
      exp_v = sb.pop_front(); obs_v = observed(); checks++;
      if (obs_v !== exp_v || id_pc !== 32'h3010 || fetch_count !== 32'd5) begin
         failures++; $display("FAIL stall_release got=%h exp=%h", obs_v, exp_v);
      end
   endtask

   task automatic test_flush();
      cycle(1'b1, 1'b0, 1'b1, 32'h4180);
      exp_v = sb.pop_front(); obs_v = observed(); checks++;
      if (obs_v !== exp_v) begin
         failures++; $display("FAIL flush_model got=%h exp=%h", obs_v, exp_v);
      end
      checks++;
      if (pc !== 32'h4180 || id_instr !== 32'h0 || id_valid !== 1'b0 || fetch_count !== 32'd5 || id_pc !== 32'h3010) begin
         failures++; $display("FAIL flush_const pc=%h instr=%h valid=%b fc=%0d id_pc=%h", pc, id_instr, id_valid, fetch_count, id_pc);
      end
   endtask

   task automatic test_stall_flush();
      cycle(1'b1, 1'b0, 1'b0, 32'h4184);   // refill IF/ID first
      exp_v = sb.pop_front(); obs_v = observed(); checks++;
      if (obs_v !== exp_v) begin
         failures++; $display("FAIL sf_refill got=%h exp=%h", obs_v, exp_v);
      end
      cycle(1'b1, 1'b1, 1'b1, 32'h5000);
      exp_v = sb.pop_front(); obs_v = observed(); checks++;
      if (obs_v !== exp_v || id_valid !== 1'b1 || pc !== 32'h4184 || id_pc !== 32'h4180) begin
         failures++; $display("FAIL stall_flush got=%h exp=%h", obs_v, exp_v);
      end
   endtask

   task automatic test_reset_mid_stall();
      cycle(1'b1, 1'b0, 1'b0, 32'h3020);
      exp_v = sb.pop_front(); obs_v = observed(); checks++;
      if (obs_v !== exp_v || pc !== 32'h3020) begin
         failures++; $display("FAIL rms_setup got=%h exp=%h", obs_v, exp_v);
      end
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
      void'(sb.pop_front());
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      exp_v = sb.pop_front(); obs_v = observed(); checks++;
      if (obs_v !== exp_v || pc !== 32'h3000 || id_valid !== 1'b0 || fetch_count !== 32'd0) begin
         failures++; $display("FAIL reset_mid_stall got=%h exp=%h", obs_v, exp_v);
      end
      cycle(1'b1, 1'b1, 1'b1, 32'h5000);   // BOOT ignores stall and flush
      exp_v = sb.pop_front(); obs_v = observed(); checks++;
      if (obs_v !== exp_v || pc !== 32'h3000 || id_valid !== 1'b0) begin
         failures++; $display("FAIL boot_ignore got=%h exp=%h", obs_v, exp_v);
      end
   endtask

   task automatic test_addr_check();
      logic [31:0] np_tab [5] = '{32'h3002, 32'h7000, 32'h3004, 32'h3008, 32'hFFFF_FFFC};
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b0, 1'b0, np_tab[i]);
         exp_v = sb.pop_front(); obs_v = observed(); checks++;
         if (obs_v !== exp_v) begin
            failures++; $display("FAIL addr_chk%0d got=%h exp=%h", i, obs_v, exp_v);
         end
         if (i == 1) begin
            checks++;
`ifdef IF_STAGE_ADDR_CHECK_EN
            if (id_exc_adel !== 1'b1 || id_instr !== 32'h0 || id_valid !== 1'b1) begin
`else
            if (id_exc_adel !== 1'b0 || id_instr !== im_word(32'h3002)) begin
`endif
               failures++; $display("FAIL adel_misalign exc=%b instr=%h valid=%b", id_exc_adel, id_instr, id_valid);
            end
         end
      end
      checks++;
      if (pc !== 32'hFFFF_FFFC || pc4 !== 32'h0) begin
         failures++; $display("FAIL pc4_wrap pc=%h pc4=%h exp pc=fffffffc pc4=0", pc, pc4);
      end
   endtask

   task automatic test_back_to_back();
      cycle(1'b1, 1'b0, 1'b1, 32'h3100);
      void'(sb.pop_front());
      for (int i = 0; i < 40; i++) begin
         cycle(1'b1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
               32'h3000 + 32'($urandom_range(0, 4095) * 4));
         exp_v = sb.pop_front(); obs_v = observed(); checks++;
         if (obs_v !== exp_v) begin
            failures++; $display("FAIL b2b%0d got=%h exp=%h", i, obs_v, exp_v);
         end
      end
   endtask

   initial begin
      reset_n = 1'b0; stall = 1'b0; flush = 1'b0; next_pc = 32'h0;
      test_reset();
      test_sequential();
      test_stall();
      test_flush();
      test_stall_flush();
      test_reset_mid_stall();
      test_addr_check();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
